// File: rtl/vinst_arb_pkg.sv
// Shared instruction/source types for the vector-instruction arbiter.
// Packaged as proj_pkgs so other array-controller blocks can reuse sa_inst_t.
package proj_pkgs;

    localparam int VARB_DEPTH = 4;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  dst;
        logic [15:0] imm;
    } sa_inst_t;

    typedef enum logic {
        SRC_HOST = 1'b0,
        SRC_SEQ  = 1'b1
    } src_t;

endpackage

// File: rtl/inst_fifo.sv
// Instruction queue: storage, read/write pointers and occupancy.
// Pops while empty are ignored; flush clears pointers and count.
module inst_fifo
    import proj_pkgs::*;
#(
    parameter int DEPTH = VARB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  sa_inst_t               i_data,
    output sa_inst_t               o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sa_inst_t          r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_push  = i_push & ~o_full & ~i_flush;
    assign w_pop   = i_pop & ~o_empty & ~i_flush;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is deliberately not reset; o_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vinst_arb.sv
// Round-robin arbiter merging host and loop-sequencer instructions into one queue.
// Readies depend only on queue state, flush and the valids, never on ird.
module vinst_arb
    import proj_pkgs::*;
#(
    parameter int DEPTH = VARB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  sa_inst_t               h_inst,
    input  logic                   h_valid,
    output logic                   h_ready,
    input  sa_inst_t               s_inst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   flush,
    output sa_inst_t               inst,
    output logic                   iavail,
    input  logic                   ird,
    output logic [$clog2(DEPTH):0] count
);

    src_t      r_last_src;
    logic      w_full;
    logic      w_empty;
    logic      w_can_push;
    logic      w_host_wins;
    logic      w_push;
    sa_inst_t  w_push_data;

    // Host wins a tie unless it was the last source granted.
    assign w_can_push  = ~w_full & ~flush;
    assign w_host_wins = h_valid & (~s_valid | (r_last_src == SRC_SEQ));
    assign h_ready     = w_can_push & w_host_wins;
    assign s_ready     = w_can_push & s_valid & ~w_host_wins;
    assign w_push      = h_ready | s_ready;
    assign w_push_data = h_ready ? h_inst : s_inst;
    assign iavail      = ~w_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_last_src <= SRC_SEQ;
        else if (h_ready) r_last_src <= SRC_HOST;
        else if (s_ready) r_last_src <= SRC_SEQ;
    end

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (ird),
        .i_flush (flush),
        .i_data  (w_push_data),
        .o_data  (inst),
        .o_count (count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_vinst_arb.sv
// Directed and random checks of vinst_arb against a queue-based reference model.
module tb_vinst_arb;
    import proj_pkgs::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    sa_inst_t               h_inst, s_inst, inst;
    logic                   h_valid, s_valid, h_ready, s_ready;
    logic                   flush, iavail, ird;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    sa_inst_t q[$];
    bit       last_host;

    vinst_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .h_inst(h_inst), .h_valid(h_valid), .h_ready(h_ready),
        .s_inst(s_inst), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush), .inst(inst), .iavail(iavail), .ird(ird), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_host = 1'b0;
    endtask

    // One cycle: drive at negedge, check against the model, then advance it.
    task automatic step(input bit hv, input bit sv, input bit rd, input bit fl, input int op);
        bit full, can, eh, es;
        @(negedge clk);
        h_valid = hv; s_valid = sv; ird = rd; flush = fl;
        h_inst  = sa_inst_t'($urandom);
        s_inst  = sa_inst_t'($urandom);
        if (op > 0) h_inst.opcode = 8'(op);
        #1;
        full = (q.size() == DEPTH);
        can  = !full && !fl;
        eh   = can && hv && (!sv || !last_host);
        es   = can && sv && !eh;
        chk("count", 64'(count), 64'(q.size()));
        chk("iavail", 64'(iavail), 64'(q.size() != 0));
        if (q.size() != 0) chk("inst", 64'(inst), 64'(q[0]));
        chk("h_ready", 64'(h_ready), 64'(eh));
        chk("s_ready", 64'(s_ready), 64'(es));
        if (fl) q.delete();
        else begin
            if (rd && q.size() != 0) void'(q.pop_front());
            if (eh) begin q.push_back(h_inst); last_host = 1'b1; end
            else if (es) begin q.push_back(s_inst); last_host = 1'b0; end
        end
    endtask

    initial begin
        reset_n = 1'b0; h_valid = 0; s_valid = 0; ird = 0; flush = 0;
        h_inst = '0; s_inst = '0;
        model_reset();
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_iavail", 64'(iavail), 64'd0);
        chk("rst_h_ready", 64'(h_ready), 64'd0);
        #11 reset_n = 1'b1;

        // Host-only ordered traffic then drain
        step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 2); step(1, 0, 0, 0, 3);
        chk("op1_head", 64'(inst.opcode), 64'd1);
        repeat (4) step(0, 0, 1, 0, 0);

        // Continuous tie from empty: H,S,H,S then both blocked at full
        repeat (6) step(1, 1, 0, 0, 0);
        chk("tie_full", 64'(count), 64'd4);

        // Full with pop: no accept this cycle, accept next
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Drain, then pop on empty, then fresh push becomes head
        repeat (5) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 9);
        step(0, 0, 0, 0, 0);
        chk("after_empty_pop_head", 64'(inst.opcode), 64'd9);

        // Flush with count=3 while popping and sequencer offering
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle with two entries queued
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        h_valid = 0; s_valid = 0; ird = 0; flush = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_iavail", 64'(iavail), 64'd0);
        model_reset();
        @(negedge clk); #2 reset_n = 1'b1;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 15) == 0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vinst_arb.md
VINST_ARB -- requirements
Module: vinst_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low; one clock only.
REQ-004 SHALL have port h_inst  input  sa_inst_t  host instruction.
REQ-005 SHALL have port h_valid  input  1  host instruction offered.
REQ-006 SHALL have port h_ready  output  1  host instruction accepted this cycle (h_valid & h_ready = transfer).
REQ-007 SHALL have port s_inst  input  sa_inst_t  loop-sequencer instruction.
REQ-008 SHALL have port s_valid  input  1  sequencer instruction offered.
REQ-009 SHALL have port s_ready  output  1  sequencer instruction accepted this cycle.
REQ-010 SHALL have port flush  input  1  synchronous clear of all queued instructions.
REQ-011 SHALL have port inst  output  sa_inst_t  head-of-queue instruction to the array controller.
REQ-012 SHALL have port iavail  output  1  inst valid (queue not empty).
REQ-013 SHALL have port ird  input  1  one-cycle pop pulse from the array controller.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL push at most one instruction per cycle; ready outputs combinational from state and valids, never from ird.
REQ-016 SHALL, when not full and not flush, grant the only valid source; both valid -> grant the source not granted last (round-robin pointer last_src).
REQ-017 SHALL update last_src only on an actual transfer; reset value = sequencer, so host wins first tie.
REQ-018 SHALL hold h_ready=s_ready=0 when full (count==DEPTH) even if ird asserted same cycle (no push-through-full).
REQ-019 SHALL hold both ready outputs 0 while flush=1.
REQ-020 SHALL drive iavail = (count!=0) and inst = storage[rd_ptr], both stable until the cycle after ird.
REQ-021 SHALL advance rd_ptr on ird & iavail; ird while empty SHALL be ignored (no pointer or count change).
REQ-022 SHALL on simultaneous push and pop keep count unchanged and advance both pointers.
REQ-023 SHALL wrap rd_ptr/wr_ptr modulo DEPTH; count width prevents full/empty ambiguity.
REQ-024 SHALL preserve FIFO order: instructions leave in acceptance order regardless of source.
REQ-025 SHALL on flush=1 set rd_ptr=wr_ptr=0, count=0 next edge; a same-cycle ird SHALL have no extra effect.
REQ-026 SHALL give latency: instruction accepted at edge N is visible on inst/iavail after edge N if queue was empty (one-cycle accept-to-available).

Reset
REQ-027 SHALL, while reset_n=0, force rd_ptr=0, wr_ptr=0, count=0, last_src=sequencer; thus iavail=0, h_ready=s_ready=0 only if the source is not valid (ready=1 on valid when empty).
REQ-028 SHALL leave storage contents unreset; inst is don't-care while iavail=0.
REQ-029 SHALL, on reset assertion mid-operation, discard all queued instructions; first accepted instruction after release SHALL be the new head.

Structure
REQ-030 SHALL take sa_inst_t from proj_pkgs; a src_t enum (SRC_HOST, SRC_SEQ) and VARB_DEPTH default SHALL be added to proj_pkgs.
REQ-031 SHALL place storage/pointers in one sub-module inst_fifo (push, pop, flush, data, count); arbitration logic in vinst_arb.
REQ-032 SHALL contain no combinational path from ird to h_ready/s_ready.

Verification
REQ-033 Host-only: push opcodes 1,2,3 on h_*, ird each cycle after -> inst shows 1,2,3 in order, count returns to 0, iavail drops.
REQ-034 Tie: h_valid=s_valid=1 continuously from reset with empty queue, ird held 0 -> grants H,S,H,S, count hits 4, both readys drop at full.
REQ-035 Full + pop: count=4, ird=1, h_valid=1 -> no accept that cycle, count=3; next cycle host accepted, count=4.
REQ-036 Empty pop: ird=1 with count=0 -> count stays 0, pointers unchanged, next push appears as head.
REQ-037 Flush: count=3, flush=1 with ird=1 and s_valid=1 -> count=0 next edge, s_ready=0 during flush, iavail=0.
REQ-038 Async reset: reset_n low mid-cycle with count=2 -> iavail=0 and count=0 immediately without clock edge.
